posit_addsub_issue: RTL and testbench
=====================================

# posit_addsub_issue

Operand issue stage placed directly upstream of the combinational posit adder/subtractor. It accepts add/subtract requests over a valid/ready handshake and converts subtraction into addition by two's-complement negation of operand B. It also classifies special cases (NaR, zero operands, exact cancellation) so the downstream stage can bypass the adder. Requests are buffered in a small in-order FIFO, and each entry is presented as an adder-ready operand pair (IN1/IN2 format) with a tag.

## Interface
- N, default 32: posit width; must match the downstream adder's N.
- DEPTH, default 2: FIFO entries; power of two, at least 2.
- TW, default 4: request tag width; the tag is passed through unchanged.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  stage can accept a request this cycle.
- req_a  input  N  operand A (posit).
- req_b  input  N  operand B (posit).
- req_sub  input  1  1 = A−B, 0 = A+B.
- req_tag  input  TW  request tag.
- iss_valid  output  1  head entry available to the adder.
- iss_ready  input  1  downstream consumes head entry.
- iss_in1  output  N  adder IN1 (= A).
- iss_in2  output  N  adder IN2 (= B or −B).
- iss_bypass  output  1  result is iss_byp_val; adder output to be ignored.
- iss_byp_val  output  N  bypass result; 0 when iss_bypass = 0.
- iss_tag  output  TW  tag of head entry.
- count  output  $clog2(DEPTH)+1  occupied entries.

## Operation
- Accept = req_valid && req_ready. Issue = iss_valid && iss_ready.
- Negation: b_eff = req_sub ? (~req_b + 1) mod 2^N : req_b. NaR (1 followed by N−1 zeros) and zero map to themselves.
- Classification, computed on accept and stored with the entry, first match wins:
  - req_a or b_eff is NaR -> bypass = 1, value NaR.
  - req_a is zero -> bypass = 1, value b_eff.
  - b_eff is zero -> bypass = 1, value req_a.
  - req_a == (~b_eff + 1) mod 2^N -> bypass = 1, value 0 (exact cancellation).
  - Otherwise bypass = 0, value 0.
- Stored entry: {req_a, b_eff, bypass, value, tag}.
- FIFO: circular write/read pointers, each wrapping at DEPTH, plus an occupancy counter. Strictly in order.
- req_ready = (count < DEPTH). It is a function of registered state only, with no combinational path from iss_ready.
- iss_valid = (count != 0). iss_* data comes from the head entry. All iss_* data outputs are forced to 0 when count == 0.
- Counter updates:
  - Accept only: count +1.
  - Issue only: count −1.
  - Both in the same cycle: count unchanged, both pointers advance.
- Full (count == DEPTH): req_ready = 0, so no accept occurs. A simultaneous issue frees an entry, but req_ready only rises in the following cycle.
- Empty: issue is impossible. There is no flow-through: an input accepted while the FIFO is empty appears at the output at the earliest one cycle later.
- Reset (asynchronous, any time, including mid-transfer) takes effect immediately and discards all entries:
  - count = 0, pointers = 0, storage cleared to 0.
  - iss_valid = 0, all iss_* data = 0, req_ready = 1.

## Timing
- Latency is 1 cycle: a request accepted at edge t is visible on iss_* after edge t, and can be issued in that cycle.
- Throughput is 1 request per cycle sustained while iss_ready = 1.
- While iss_valid && !iss_ready, all iss_* outputs stay stable until issue.
- The requester must hold req_* stable while req_valid && !req_ready.
- Outputs are registered or decoded from registered state; the only combinational path is storage-read muxing by the read pointer.
- The downstream adder is combinational, so its OUT is valid in the same cycle as iss_in1/iss_in2.

## Test plan
- Reset: assert rst_n = 0 mid-cycle -> immediately count = 0, iss_valid = 0, req_ready = 1, iss_in1 = iss_in2 = 0.
- Plain add: A = 0x40000000, B = 0x40000000, sub = 0, tag = 1 -> next cycle iss_valid = 1, in1 = in2 = 0x40000000, bypass = 0, byp_val = 0, tag = 1.
- Subtraction:
  - A = 0x40000000, B = 0x40000000, sub = 1 -> in2 = 0xC0000000, bypass = 1, byp_val = 0x00000000.
  - A = 0x50000000, B = 0x40000000, sub = 1 -> in2 = 0xC0000000, bypass = 0.
- Special cases:
  - A = 0x80000000, B = 0x40000000 -> bypass = 1, byp_val = 0x80000000.
  - A = 0x30000000, B = 0, sub = 1 -> in2 = 0, bypass = 1, byp_val = 0x30000000.
  - A = 0, B = 0x40000000, sub = 1 -> bypass = 1, byp_val = 0xC0000000.
- Backpressure: iss_ready = 0, offer tags 1, 2, 3 back-to-back -> tags 1 and 2 accepted, req_ready = 0 with count = 2, tag 3 held. iss_* shows tag 1 and stays stable. Then raise iss_ready -> issue order 1, 2, 3; count never exceeds 2; req_ready rises the cycle after the first issue.
- Reset mid-operation: count = 2, assert rst_n = 0 -> iss_valid drops immediately. After release, a new request (tag 5) is issued alone with no stale entries.

Source files
------------

// File: rtl/posit_addsub_issue_if.sv
// Request and issue channels of the posit add/sub issue stage.
// slave = the issue stage itself; master = requester plus downstream adder.
interface posit_addsub_issue_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned TW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [N-1:0]  req_a;
  logic [N-1:0]  req_b;
  logic          req_sub;
  logic [TW-1:0] req_tag;

  logic          iss_valid;
  logic          iss_ready;
  logic [N-1:0]  iss_in1;
  logic [N-1:0]  iss_in2;
  logic          iss_bypass;
  logic [N-1:0]  iss_byp_val;
  logic [TW-1:0] iss_tag;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_tag, iss_ready,
    output req_ready, iss_valid, iss_in1, iss_in2, iss_bypass, iss_byp_val, iss_tag
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, req_tag, iss_ready,
    input  req_ready, iss_valid, iss_in1, iss_in2, iss_bypass, iss_byp_val, iss_tag
  );
endinterface

// File: rtl/posit_addsub_issue.sv
// Posit add/sub issue stage: negates B for subtraction, classifies bypass cases
// and buffers adder-ready operand pairs in a small in-order FIFO.
module posit_addsub_issue #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TW    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  posit_addsub_issue_if.slave      bus,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    logic [N-1:0]  in1;
    logic [N-1:0]  in2;
    logic          bypass;
    logic [N-1:0]  val;
    logic [TW-1:0] tag;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;

  logic          accept_c;
  logic          issue_c;
  logic [N-1:0]  b_eff_c;
  logic [N-1:0]  b_neg_c;
  entry_t        new_c;
  entry_t        head_c;

  assign count         = cnt_q;
  assign bus.req_ready = (cnt_q < CW'(DEPTH));
  assign bus.iss_valid = (cnt_q != '0);
  assign accept_c      = bus.req_valid && bus.req_ready;
  assign issue_c       = bus.iss_valid && bus.iss_ready;

  // Negate B for subtraction and classify cases the adder can skip.
  always_comb begin
    b_eff_c = bus.req_sub ? (~bus.req_b + N'(1)) : bus.req_b;
    b_neg_c = ~b_eff_c + N'(1);
    new_c        = '0;
    new_c.in1    = bus.req_a;
    new_c.in2    = b_eff_c;
    new_c.tag    = bus.req_tag;
    new_c.bypass = 1'b1;
    if (bus.req_a == NAR || b_eff_c == NAR) begin
      new_c.val = NAR;
    end else if (bus.req_a == '0) begin
      new_c.val = b_eff_c;
    end else if (b_eff_c == '0) begin
      new_c.val = bus.req_a;
    end else if (bus.req_a == b_neg_c) begin
      new_c.val = '0;
    end else begin
      new_c.bypass = 1'b0;
      new_c.val    = '0;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (accept_c) begin
        mem[wr_ptr] <= new_c;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (issue_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (accept_c && !issue_c) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (issue_c && !accept_c) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Head entry, forced to zero while empty.
  always_comb begin
    head_c = '0;
    if (bus.iss_valid) begin
      head_c = mem[rd_ptr];
    end
  end

  assign bus.iss_in1     = head_c.in1;
  assign bus.iss_in2     = head_c.in2;
  assign bus.iss_bypass  = head_c.bypass;
  assign bus.iss_byp_val = head_c.val;
  assign bus.iss_tag     = head_c.tag;

endmodule

// File: tb/tb_posit_addsub_issue.sv
// Directed self-checking bench for posit_addsub_issue (N=32, DEPTH=2, TW=4).
module tb_posit_addsub_issue;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned TW    = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] count;
  int            errors;
  int            checks;

  posit_addsub_issue_if #(.N(N), .TW(TW)) bus ();

  posit_addsub_issue #(.N(N), .DEPTH(DEPTH), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = 1'b0;
    bus.req_tag   = '0;
    bus.iss_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_a     = 32'h40000000;
    bus.req_b     = 32'h10000000;
    bus.req_tag   = 4'd9;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (count !== CW'(1)) begin
      errors++; $display("FAIL reset_preload_count: got %0d want 1", count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== CW'(0)) begin
      errors++; $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if (bus.iss_valid !== 1'b0) begin
      errors++; $display("FAIL reset_iss_valid: got %b want 0", bus.iss_valid);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
    end
    checks++;
    if (bus.iss_in1 !== 32'h0 || bus.iss_in2 !== 32'h0 || bus.iss_tag !== 4'h0) begin
      errors++; $display("FAIL reset_iss_data: got in1=%h in2=%h tag=%h want 0", bus.iss_in1, bus.iss_in2, bus.iss_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_plain_add();
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_a     = 32'h40000000;
    bus.req_b     = 32'h40000000;
    bus.req_sub   = 1'b0;
    bus.req_tag   = 4'd1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.iss_valid !== 1'b1 || bus.iss_in1 !== 32'h40000000 || bus.iss_in2 !== 32'h40000000) begin
      errors++; $display("FAIL add_operands: got v=%b in1=%h in2=%h want v=1 in1=40000000 in2=40000000",
                         bus.iss_valid, bus.iss_in1, bus.iss_in2);
    end
    checks++;
    if (bus.iss_bypass !== 1'b0 || bus.iss_byp_val !== 32'h0 || bus.iss_tag !== 4'd1) begin
      errors++; $display("FAIL add_class: got byp=%b val=%h tag=%0d want byp=0 val=0 tag=1",
                         bus.iss_bypass, bus.iss_byp_val, bus.iss_tag);
    end
    bus.iss_ready = 1'b1;
    @(posedge clk); #1;
    bus.iss_ready = 1'b0;
    checks++;
    if (count !== CW'(0) || bus.iss_valid !== 1'b0 || bus.iss_in1 !== 32'h0) begin
      errors++; $display("FAIL add_drain: got count=%0d v=%b in1=%h want 0 0 0", count, bus.iss_valid, bus.iss_in1);
    end
  endtask

  // Subtraction and special-case classification table.
  task automatic test_classify();
    logic [N-1:0] ta  [6] = '{32'h40000000, 32'h50000000, 32'h80000000, 32'h30000000, 32'h00000000, 32'h40000000};
    logic [N-1:0] tb  [6] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h00000000, 32'h40000000, 32'h80000000};
    logic         ts  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [N-1:0] ei2 [6] = '{32'hC0000000, 32'hC0000000, 32'h40000000, 32'h00000000, 32'hC0000000, 32'h80000000};
    logic         eby [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [N-1:0] evl [6] = '{32'h00000000, 32'h00000000, 32'h80000000, 32'h30000000, 32'hC0000000, 32'h80000000};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_a     = ta[i];
      bus.req_b     = tb[i];
      bus.req_sub   = ts[i];
      bus.req_tag   = TW'(i + 2);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      checks++;
      if (bus.iss_in1 !== ta[i] || bus.iss_in2 !== ei2[i] || bus.iss_tag !== TW'(i + 2)) begin
        errors++; $display("FAIL classify_%0d_operands: got in1=%h in2=%h tag=%0d want in1=%h in2=%h tag=%0d",
                           i, bus.iss_in1, bus.iss_in2, bus.iss_tag, ta[i], ei2[i], i + 2);
      end
      checks++;
      if (bus.iss_bypass !== eby[i] || bus.iss_byp_val !== evl[i]) begin
        errors++; $display("FAIL classify_%0d_bypass: got byp=%b val=%h want byp=%b val=%h",
                           i, bus.iss_bypass, bus.iss_byp_val, eby[i], evl[i]);
      end
      bus.iss_ready = 1'b1;
      @(posedge clk); #1;
      bus.iss_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    bus.iss_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_sub   = 1'b0;
    bus.req_b     = 32'h10000000;
    bus.req_a     = 32'h40000001;
    bus.req_tag   = 4'd1;
    @(posedge clk); #1;
    bus.req_a     = 32'h40000002;
    bus.req_tag   = 4'd2;
    @(posedge clk); #1;
    checks++;
    if (count !== CW'(2) || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: got count=%0d ready=%b want 2 0", count, bus.req_ready);
    end
    bus.req_a     = 32'h40000003;
    bus.req_tag   = 4'd3;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (count !== CW'(2) || bus.iss_tag !== 4'd1 || bus.iss_in1 !== 32'h40000001 || bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: got count=%0d tag=%0d in1=%h ready=%b want 2 1 40000001 0",
                           k, count, bus.iss_tag, bus.iss_in1, bus.req_ready);
      end
    end
    bus.iss_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (count !== CW'(1) || bus.iss_tag !== 4'd2 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_issue1: got count=%0d tag=%0d ready=%b want 1 2 1", count, bus.iss_tag, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (count !== CW'(1) || bus.iss_tag !== 4'd3 || bus.iss_in1 !== 32'h40000003) begin
      errors++; $display("FAIL bp_issue2: got count=%0d tag=%0d in1=%h want 1 3 40000003", count, bus.iss_tag, bus.iss_in1);
    end
    @(posedge clk); #1;
    bus.iss_ready = 1'b0;
    checks++;
    if (count !== CW'(0) || bus.iss_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got count=%0d v=%b want 0 0", count, bus.iss_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus.iss_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_a     = 32'h20000000;
    bus.req_b     = 32'h10000000;
    bus.req_sub   = 1'b0;
    for (int t = 6; t <= 9; t++) begin
      bus.req_tag = TW'(t);
      @(posedge clk); #1;
      checks++;
      if (count !== CW'(1) || bus.iss_tag !== TW'(t) || bus.req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_tag%0d: got count=%0d tag=%0d ready=%b want 1 %0d 1",
                           t, count, bus.iss_tag, bus.req_ready, t);
      end
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    bus.iss_ready = 1'b0;
    checks++;
    if (count !== CW'(0) || bus.iss_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got count=%0d v=%b want 0 0", count, bus.iss_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    bus.iss_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_a     = 32'h40000000;
    bus.req_b     = 32'h10000000;
    bus.req_tag   = 4'd11;
    @(posedge clk); #1;
    bus.req_tag   = 4'd12;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (count !== CW'(2)) begin
      errors++; $display("FAIL rmid_fill: got count=%0d want 2", count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.iss_valid !== 1'b0 || count !== CW'(0) || bus.iss_tag !== 4'd0) begin
      errors++; $display("FAIL rmid_drop: got v=%b count=%0d tag=%0d want 0 0 0", bus.iss_valid, count, bus.iss_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_a     = 32'h30000000;
    bus.req_tag   = 4'd5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (count !== CW'(1) || bus.iss_tag !== 4'd5 || bus.iss_in1 !== 32'h30000000) begin
      errors++; $display("FAIL rmid_new: got count=%0d tag=%0d in1=%h want 1 5 30000000", count, bus.iss_tag, bus.iss_in1);
    end
    bus.iss_ready = 1'b1;
    @(posedge clk); #1;
    bus.iss_ready = 1'b0;
    checks++;
    if (count !== CW'(0) || bus.iss_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_alone: got count=%0d v=%b want 0 0", count, bus.iss_valid);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_plain_add();
    test_classify();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
